mar_mdr_mem_unit: RTL and testbench
===================================

Name: mar_mdr_mem_unit

Overview:
- Memory-side datapath stage directly downstream of the processor control sequencer.
- Holds the MAR and MDR registers and a single-port word memory, and executes the sequencer's register and memory strobes.
- Loads MAR/MDR from the ALU output bus, performs fixed-latency reads and single-cycle writes, and drives MDR onto the B bus.

Parameters:
- DATA_W, 18, word width (bus, MDR, memory word).
- ADDR_W, 13, MAR width (instruction address field).
- DEPTH, 256, memory words implemented.
- READ_LAT, 2, cycles from read launch until read data is valid (1..4).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wMAR  in  1  load MAR from bus_in[ADDR_W-1:0].
- rMAR  in  1  MAR address enable; a memory access launches only when rMAR=1.
- rMem  in  1  read strobe.
- wMem  in  1  write strobe.
- wMDRmem  in  1  load MDR from read-data register.
- wMDRbus  in  1  load MDR from bus_in.
- rMDR  in  1  drive MDR onto bBus.
- bus_in  in  DATA_W  ALU output bus.
- bBus  out  DATA_W  MDR when rMDR=1, else 0.
- mar_q  out  ADDR_W  current MAR, for debug.
- rd_valid  out  1  read data register holds data for the current MAR.
- busy  out  1  read in flight.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, asynchronous):
  - MAR=0, MDR=0, rdata=0.
  - rd_valid=0, busy=0, err=0, FSM=IDLE.
  - Memory contents are not cleared.
- Strobes are sampled on posedge clk; the sequencer changes them on negedge.
- MAR: on wMAR, MAR <= bus_in[ADDR_W-1:0]. Any MAR load clears rd_valid and aborts an in-flight read (FSM -> IDLE, busy=0).
- MDR load priority:
  - wMDRbus: MDR <= bus_in.
  - else wMDRmem with rd_valid=1: MDR <= rdata.
  - wMDRmem with rd_valid=0: MDR holds, err set.
  - wMDRbus and wMDRmem together: bus wins, err set.
- FSM states IDLE, RD_WAIT, RD_DONE.
  - IDLE: rMem&rMAR&~wMem -> RD_WAIT, busy=1, latency counter=READ_LAT-1.
  - RD_WAIT: counter decrements each cycle. At 0: rdata <= mem[MAR mod DEPTH], rd_valid=1, busy=0 -> RD_DONE.
  - RD_DONE: holds while rMem stays high (a repeated rMem does not relaunch). rMem low -> IDLE, rd_valid retained.
- A new rMem rising after IDLE launches a fresh read and clears rd_valid at launch.
- Write: wMem&rMAR in IDLE or RD_DONE -> mem[MAR mod DEPTH] <= MDR in that cycle.
  - If the write address equals the last read address, rd_valid is cleared.
  - MDR value sampled is the pre-edge value (a same-cycle wMDRbus affects the next write only).
- Simultaneous events:
  - rMem&wMem in the same cycle: write performed, no read, err set.
  - wMem during RD_WAIT: ignored, err set.
  - rMem or wMem without rMAR: ignored, no error.
- bBus is combinational: rMDR ? MDR : 0.
- err clears only on reset.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- Defined:
  - An access with MAR >= DEPTH is suppressed: a write is dropped; a read returns 0 with rd_valid=1 after normal latency.
  - err is set in both cases.
- Undefined: address wraps modulo DEPTH silently.

Decomposition:
- Shared package proc_pkg:
  - DATA_W/ADDR_W defaults.
  - FSM state enum (IDLE, RD_WAIT, RD_DONE).
  - Instruction field constants (opcode [17:15], mode [14:13], address [12:0]), shared with the control sequencer.
- One sub-module, mem_array:
  - Single-port synchronous RAM, DEPTH x DATA_W, registered read output.
  - READ_LAT-1 extra pipeline stages are added in the parent.

Test Plan:
- Reset mid-read: bus_in=5, wMAR, then rMem&rMAR. Assert reset in RD_WAIT -> all outputs 0, busy=0. Memory preserved: a later read of address 5 returns its prior value.
- Write/read round trip: bus_in=0x00A1 into MAR, bus_in=0x2F00F into MDR, wMem&rMAR. Then clear MDR, rMem&rMAR -> rd_valid exactly READ_LAT cycles later; wMDRmem -> MDR=0x2F00F; rMDR -> bBus=0x2F00F.
- Conflicts: rMem&wMem together -> write occurs, err=1. wMDRbus&wMDRmem together -> MDR=bus_in, err=1.
- Premature wMDRmem one cycle after launch (READ_LAT=2) -> MDR unchanged, err=1.
- MAR reload during RD_WAIT -> busy=0, rd_valid=0, no rdata update.
- Bounds: MAR=300, DEPTH=256, write 0x111 then read.
  - Without MEM_BOUNDS_CHECK_EN: address 44 holds 0x111.
  - With MEM_BOUNDS_CHECK_EN: read returns 0, address 44 unchanged, err=1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor datapath: default widths, the memory-stage
// FSM encoding and the instruction field layout used by the control sequencer.
package proc_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int ADDR_W_DEF = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } mem_state_e;

    // Instruction word layout: opcode | addressing mode | direct address
    localparam int OPC_MSB  = 17;
    localparam int OPC_LSB  = 15;
    localparam int MODE_MSB = 14;
    localparam int MODE_LSB = 13;
    localparam int IADR_MSB = 12;
    localparam int IADR_LSB = 0;

endpackage

// File: rtl/mar_mdr_mem_unit_if.sv
// Sequencer-to-memory-stage strobe bus; the sequencer is master, the memory stage slave.
interface mar_mdr_mem_unit_if #(
    parameter int DATA_W = proc_pkg::DATA_W_DEF,
    parameter int ADDR_W = proc_pkg::ADDR_W_DEF
);
    logic              wMAR;
    logic              rMAR;
    logic              rMem;
    logic              wMem;
    logic              wMDRmem;
    logic              wMDRbus;
    logic              rMDR;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bBus;
    logic [ADDR_W-1:0] mar_q;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output wMAR, rMAR, rMem, wMem, wMDRmem, wMDRbus, rMDR, bus_in,
        input  bBus, mar_q, rd_valid, busy, err
    );

    modport slave (
        input  wMAR, rMAR, rMem, wMem, wMDRmem, wMDRbus, rMDR, bus_in,
        output bBus, mar_q, rd_valid, busy, err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are
// deliberately never reset so they survive a datapath reset.
module mem_array #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_q
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end
endmodule

// File: rtl/mar_mdr_mem_unit.sv
// Memory-side datapath stage: MAR/MDR registers, fixed-latency reads and single-cycle
// writes into a word RAM. Optional macro MEM_BOUNDS_CHECK_EN suppresses accesses with MAR >= DEPTH.
module mar_mdr_mem_unit
    import proc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    mar_mdr_mem_unit_if.slave  mif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [AW-1:0]     last_addr_q, last_addr_d;

    logic [AW-1:0]     mem_addr;
    logic              addr_ok;
    logic              rd_req, wr_req, launch, wr_fire, wr_perform;
    logic [DATA_W-1:0] ram_dout, pipe_out;

    assign mem_addr = AW'(mar_q % DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
    assign addr_ok = (32'(mar_q) < 32'(DEPTH));
`else
    assign addr_ok = 1'b1;
`endif

    assign rd_req     = mif.rMem & mif.rMAR;
    assign wr_req     = mif.wMem & mif.rMAR;
    // A MAR load in the same cycle wins over a read launch: the read would target a stale address
    assign launch     = rd_req & ~mif.wMem & ~mif.wMAR & (state_q == IDLE);
    assign wr_fire    = wr_req & (state_q != RD_WAIT);
    assign wr_perform = wr_fire & addr_ok;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_perform),
        .re      (launch),
        .addr    (mem_addr),
        .wdata   (mdr_q),
        .rdata_q (ram_dout)
    );

    // RAM output is valid one cycle after launch; the remaining latency is a free-running delay line
    generate
        if (READ_LAT > 1) begin : g_pipe
            for (genvar gi = 0; gi < READ_LAT - 1; gi++) begin : g_stage
                logic [DATA_W-1:0] stage_q;
                logic [DATA_W-1:0] stage_d;
                if (gi == 0) begin : g_first
                    assign stage_d = ram_dout;
                end else begin : g_next
                    assign stage_d = g_stage[gi-1].stage_q;
                end
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign pipe_out = g_stage[READ_LAT-2].stage_q;
        end else begin : g_nopipe
            assign pipe_out = ram_dout;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        rdata_d     = rdata_q;
        rd_valid_d  = rd_valid_q;
        busy_d      = busy_q;
        err_d       = err_q;
        lat_cnt_d   = lat_cnt_q;
        last_addr_d = last_addr_q;

        if (mif.wMDRbus) begin
            mdr_d = mif.bus_in;
            if (mif.wMDRmem) begin
                err_d = 1'b1;
            end
        end else if (mif.wMDRmem) begin
            if (rd_valid_q) begin
                mdr_d = rdata_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (wr_req && (rd_req || state_q == RD_WAIT)) begin
            err_d = 1'b1;
        end
        if ((launch || wr_fire) && !addr_ok) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d     = RD_WAIT;
                    busy_d      = 1'b1;
                    rd_valid_d  = 1'b0;
                    lat_cnt_d   = 2'(READ_LAT - 1);
                    last_addr_d = mem_addr;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d    = RD_DONE;
                    busy_d     = 1'b0;
                    rd_valid_d = 1'b1;
                    rdata_d    = addr_ok ? pipe_out : '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            RD_DONE: begin
                if (!mif.rMem) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (wr_perform && mem_addr == last_addr_q) begin
            rd_valid_d = 1'b0;
        end

        // MAR reload invalidates everything tied to the old address, including a read in flight
        if (mif.wMAR) begin
            mar_d      = mif.bus_in[ADDR_W-1:0];
            rd_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
            rdata_d    = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            mdr_q       <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lat_cnt_q   <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            lat_cnt_q   <= lat_cnt_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign mif.bBus     = mif.rMDR ? mdr_q : '0;
    assign mif.mar_q    = mar_q;
    assign mif.rd_valid = rd_valid_q;
    assign mif.busy     = busy_q;
    assign mif.err      = err_q;
endmodule

// File: tb/tb_mar_mdr_mem_unit.sv
// Directed bench for mar_mdr_mem_unit: a cycle table for the main write/read/conflict
// flow plus hand-written sequences for reset, aborts, premature loads and bounds.
module tb_mar_mdr_mem_unit;
    localparam int DW    = 18;
    localparam int AW    = 13;
    localparam int DEPTH = 256;
    localparam int RL    = 2;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    // strobe vector bit order: {wMAR, rMAR, rMem, wMem, wMDRmem, wMDRbus, rMDR}
    localparam logic [6:0] S_WMAR  = 7'h40;
    localparam logic [6:0] S_RMAR  = 7'h20;
    localparam logic [6:0] S_RMEM  = 7'h10;
    localparam logic [6:0] S_WMEM  = 7'h08;
    localparam logic [6:0] S_WMDRM = 7'h04;
    localparam logic [6:0] S_WMDRB = 7'h02;
    localparam logic [6:0] S_RMDR  = 7'h01;

    typedef struct packed {
        logic [6:0]    strb;
        logic [DW-1:0] bus;
        logic [DW-1:0] e_bbus;
        logic [AW-1:0] e_mar;
        logic          e_rdv;
        logic          e_busy;
        logic          e_err;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;
    vec_t vecs [17];

    mar_mdr_mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

    mar_mdr_mem_unit #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .READ_LAT (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] s, input logic [DW-1:0] b,
                                input logic [DW-1:0] eb, input logic [AW-1:0] em,
                                input logic rv, input logic bz, input logic er);
        vec_t v;
        v.strb = s; v.bus = b; v.e_bbus = eb; v.e_mar = em;
        v.e_rdv = rv; v.e_busy = bz; v.e_err = er;
        return v;
    endfunction

    function automatic logic [33:0] pk(input logic [DW-1:0] b, input logic [AW-1:0] m,
                                       input logic rv, input logic bz, input logic er);
        return {b, m, rv, bz, er};
    endfunction

    task automatic chk(input string nm, input logic [33:0] exp);
        logic [33:0] act;
        act = {mif.bBus, mif.mar_q, mif.rd_valid, mif.busy, mif.err};
        n_chk++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: bBus=%h mar=%0d rdv=%b busy=%b err=%b",
                     nm, act[33:16], act[15:3], act[2], act[1], act[0]);
        end else begin
            $display("FAIL %s: got bBus=%h mar=%0d rdv=%b busy=%b err=%b, want bBus=%h mar=%0d rdv=%b busy=%b err=%b",
                     nm, act[33:16], act[15:3], act[2], act[1], act[0],
                     exp[33:16], exp[15:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic set_strb(input logic [6:0] s, input logic [DW-1:0] b);
        {mif.wMAR, mif.rMAR, mif.rMem, mif.wMem, mif.wMDRmem, mif.wMDRbus, mif.rMDR} = s;
        mif.bus_in = b;
    endtask

    task automatic drive(input logic [6:0] s, input logic [DW-1:0] b);
        @(negedge clk);
        set_strb(s, b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_strb(7'h00, '0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] eb,
                           input logic er, input string nm);
        drive(S_WMAR, DW'(a));
        repeat (RL + 1) drive(S_RMAR | S_RMEM, '0);
        drive(S_WMDRM | S_RMDR, '0);
        chk(nm, pk(eb, a, 1'b1, 1'b0, er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(7'h00,                      18'h0,     18'h0,     13'h0,  0, 0, 0);
        vecs[1]  = mk(S_WMAR,                     18'h000A1, 18'h0,     13'hA1, 0, 0, 0);
        vecs[2]  = mk(S_WMDRB | S_RMDR,           18'h2F00F, 18'h2F00F, 13'hA1, 0, 0, 0);
        vecs[3]  = mk(S_WMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 0, 0, 0);
        vecs[4]  = mk(S_WMDRB,                    18'h0,     18'h0,     13'hA1, 0, 0, 0);
        vecs[5]  = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 0, 1, 0);
        vecs[6]  = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 0, 1, 0);
        vecs[7]  = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 1, 0, 0);
        vecs[8]  = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 1, 0, 0);
        vecs[9]  = mk(S_RMDR,                     18'h0,     18'h0,     13'hA1, 1, 0, 0);
        vecs[10] = mk(S_WMDRM | S_RMDR,           18'h0,     18'h2F00F, 13'hA1, 1, 0, 0);
        vecs[11] = mk(S_WMDRB | S_WMDRM | S_RMDR, 18'h12345, 18'h12345, 13'hA1, 1, 0, 1);
        vecs[12] = mk(S_RMEM | S_WMEM | S_RMAR,   18'h0,     18'h0,     13'hA1, 0, 0, 1);
        vecs[13] = mk(S_RMEM | S_RMAR | S_WMDRB,  18'h0,     18'h0,     13'hA1, 0, 1, 1);
        vecs[14] = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 0, 1, 1);
        vecs[15] = mk(S_RMEM | S_RMAR,            18'h0,     18'h0,     13'hA1, 1, 0, 1);
        vecs[16] = mk(S_WMDRM | S_RMDR,           18'h0,     18'h12345, 13'hA1, 1, 0, 1);

        set_strb(7'h00, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].strb, vecs[i].bus);
            chk($sformatf("vec%0d", i),
                pk(vecs[i].e_bbus, vecs[i].e_mar, vecs[i].e_rdv, vecs[i].e_busy, vecs[i].e_err));
        end

        // reset in the middle of a read; memory must survive it
        do_reset();
        drive(S_WMAR, 18'd5);
        drive(S_WMDRB, 18'h0ABCD);
        drive(S_WMEM | S_RMAR, '0);
        drive(S_WMDRB, '0);
        drive(S_RMEM | S_RMAR, '0);
        chk("rst_launch", pk(18'h0, 13'd5, 0, 1, 0));
        #2;
        set_strb(S_RMDR, '0);
        reset = 1'b0;
        #1;
        chk("rst_async", pk(18'h0, 13'h0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        do_read(13'd5, 18'h0ABCD, 1'b0, "rst_mem_kept");

        // wMDRmem one cycle after launch
        do_reset();
        drive(S_WMAR, 18'h000A1);
        drive(S_WMDRB, 18'h00777);
        drive(S_RMEM | S_RMAR, '0);
        drive(S_RMEM | S_RMAR | S_WMDRM | S_RMDR, '0);
        chk("early_mdrmem", pk(18'h00777, 13'hA1, 0, 1, 1));
        drive(S_RMEM | S_RMAR, '0);
        chk("early_done", pk(18'h0, 13'hA1, 1, 0, 1));
        drive(S_WMDRM | S_RMDR, '0);
        chk("early_load", pk(18'h12345, 13'hA1, 1, 0, 1));

        // MAR reload while the read is in flight
        do_reset();
        do_read(13'd5, 18'h0ABCD, 1'b0, "abort_pre");
        drive(S_WMAR, 18'h000A1);
        drive(S_RMEM | S_RMAR, '0);
        chk("abort_launch", pk(18'h0, 13'hA1, 0, 1, 0));
        drive(S_WMAR, 18'd5);
        chk("abort_reload", pk(18'h0, 13'd5, 0, 0, 0));
        drive(7'h00, '0);
        drive(7'h00, '0);
        chk("abort_quiet", pk(18'h0, 13'd5, 0, 0, 0));
        drive(S_WMDRM | S_RMDR, '0);
        chk("abort_nodata", pk(18'h0ABCD, 13'd5, 0, 0, 1));

        // out-of-range address: aliases without the check, suppressed with it
        do_reset();
        drive(S_WMAR, 18'd44);
        drive(S_WMDRB, 18'h00222);
        drive(S_WMEM | S_RMAR, '0);
        drive(S_WMAR, 18'd300);
        drive(S_WMDRB, 18'h00111);
        drive(S_WMEM | S_RMAR, '0);
        chk("bnd_write", pk(18'h0, 13'd300, 0, 0, BCHK));
        do_read(13'd300, BCHK ? 18'h0 : 18'h00111, BCHK, "bnd_read");
        do_read(13'd44, BCHK ? 18'h00222 : 18'h00111, BCHK, "bnd_alias");

        // read and write strobed together: write wins, err
        do_reset();
        drive(S_WMAR, 18'd7);
        drive(S_WMDRB, 18'h00155);
        drive(S_RMEM | S_WMEM | S_RMAR, '0);
        chk("rw_conflict", pk(18'h0, 13'd7, 0, 0, 1));
        drive(S_WMDRB, '0);
        do_read(13'd7, 18'h00155, 1'b1, "rw_written");

        // both MDR loads at once from a clean state
        do_reset();
        drive(S_WMDRB | S_WMDRM | S_RMDR, 18'h00F0F);
        chk("mdr_conflict", pk(18'h00F0F, 13'h0, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
